// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline buffer: DEPTH-entry FIFO between execute and memory stages.
// Optional macro EX_MEM_FWD_EN adds a forwarding port for the newest register-writing entry.
module ex_mem_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_c_out,
  input  logic [4:0]   rd_addr,
  input  logic [3:0]   ctl,
  input  logic [63:0]  store_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_result,
  output logic [63:0]  out_store_data,
  output logic [4:0]   out_rd_addr,
  output logic [3:0]   out_ctl,
  output logic         out_zero,
  output logic         out_c_out,
  output logic [2:0]   occupancy
`ifdef EX_MEM_FWD_EN
  ,
  output logic         fwd_valid,
  output logic [4:0]   fwd_rd,
  output logic [63:0]  fwd_data
`endif
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [127:0] res;
    logic [63:0]  sd;
    logic [4:0]   rd;
    logic [3:0]   ctl;
    logic         z;
    logic         c;
  } entry_t;

  entry_t     r_mem [DEPTH];
  ptr_t       r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count;

  entry_t     w_wr_entry;
  entry_t     w_head;
  logic       w_push, w_pop;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign out_valid = (r_count != 3'd0);
  assign in_ready  = (r_count < 3'(DEPTH)) || out_ready;
  assign occupancy = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Upper result half only carries meaning for wide (mul/div) operations.
  always_comb begin
    w_wr_entry.res = {ctl[3] ? alu_result[127:64] : 64'h0, alu_result[63:0]};
    w_wr_entry.sd  = store_data;
    w_wr_entry.rd  = rd_addr;
    w_wr_entry.ctl = ctl;
    w_wr_entry.z   = alu_zero;
    w_wr_entry.c   = alu_c_out;
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    out_result     = '0;
    out_store_data = '0;
    out_rd_addr    = '0;
    out_ctl        = '0;
    out_zero       = 1'b0;
    out_c_out      = 1'b0;
    if (out_valid) begin
      out_result     = w_head.res;
      out_store_data = w_head.sd;
      out_rd_addr    = w_head.rd;
      out_ctl        = w_head.ctl;
      out_zero       = w_head.z;
      out_c_out      = w_head.c;
    end
  end

`ifdef EX_MEM_FWD_EN
  // Walk oldest to newest so the last match wins.
  always_comb begin
    ptr_t w_idx;
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    w_idx     = r_rd_ptr;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_idx = r_rd_ptr + ptr_t'(i);
      if ((3'(i) < r_count) && r_mem[w_idx].ctl[2] && (r_mem[w_idx].rd != 5'd0)) begin
        fwd_valid = 1'b1;
        fwd_rd    = r_mem[w_idx].rd;
        fwd_data  = r_mem[w_idx].res[63:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a queue-based FIFO model.
module tb_ex_mem_stage;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [127:0] alu_result;
  logic         alu_zero, alu_c_out;
  logic [4:0]   rd_addr;
  logic [3:0]   ctl;
  logic [63:0]  store_data;
  logic         flush;
  logic         out_valid, out_ready;
  logic [127:0] out_result;
  logic [63:0]  out_store_data;
  logic [4:0]   out_rd_addr;
  logic [3:0]   out_ctl;
  logic         out_zero, out_c_out;
  logic [2:0]   occupancy;
`ifdef EX_MEM_FWD_EN
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [63:0]  fwd_data;
`endif

  ex_mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_c_out(alu_c_out),
    .rd_addr(rd_addr), .ctl(ctl), .store_data(store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr), .out_ctl(out_ctl),
    .out_zero(out_zero), .out_c_out(out_c_out), .occupancy(occupancy)
`ifdef EX_MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] res;
    logic [63:0]  sd;
    logic [4:0]   rd;
    logic [3:0]   ctl;
    logic         z;
    logic         c;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    ent_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    chk("in_ready", in_ready, (q.size() < DEPTH) || out_ready);
    chk("out_valid", out_valid, q.size() > 0);
    chk("occupancy", occupancy, q.size());
    chk("out_result", out_result, h.res);
    chk("out_store_data", out_store_data, h.sd);
    chk("out_rd_addr", out_rd_addr, h.rd);
    chk("out_ctl", out_ctl, h.ctl);
    chk("out_zero", out_zero, h.z);
    chk("out_c_out", out_c_out, h.c);
`ifdef EX_MEM_FWD_EN
    begin
      logic fv; logic [4:0] fr; logic [63:0] fd;
      fv = 0; fr = 0; fd = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!fv && q[i].ctl[2] && q[i].rd != 0) begin
          fv = 1; fr = q[i].rd; fd = q[i].res[63:0];
        end
      end
      chk("fwd_valid", fwd_valid, fv);
      chk("fwd_rd", fwd_rd, fr);
      chk("fwd_data", fwd_data, fd);
    end
`endif
  endtask

  // Compare this cycle, advance the model by the same inputs, then cross the clock edge.
  task automatic tick();
    bit acc;
    ent_t e;
    #1;
    compare();
    acc = in_valid && ((q.size() < DEPTH) || out_ready);
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        e.res = {ctl[3] ? alu_result[127:64] : 64'h0, alu_result[63:0]};
        e.sd = store_data; e.rd = rd_addr; e.ctl = ctl; e.z = alu_zero; e.c = alu_c_out;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] res, input logic [4:0] rd,
                       input logic [3:0] c, input logic ordy, input logic fl);
    in_valid = v; alu_result = res; rd_addr = rd; ctl = c; out_ready = ordy; flush = fl;
    store_data = ~res[63:0]; alu_zero = res[0]; alu_c_out = res[1];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 3'd0);
    chk("rst_out_result", out_result, 128'h0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Single push then drain
    drive(1, 128'h5, 5'd3, 4'b0100, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_result", out_result, 128'h5);
    chk("lat_out_rd", out_rd_addr, 5'd3);
    tick();
    chk("lat_drained", occupancy, 3'd0);

    // Fill to DEPTH with output stalled; third entry is held
    drive(1, 128'h11, 5'd1, 4'b0000, 0, 0); tick();
    drive(1, 128'h22, 5'd2, 4'b0000, 0, 0); tick();
    drive(1, 128'h33, 5'd4, 4'b0000, 0, 0);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_occupancy", occupancy, 3'd2);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("pop1", out_result, 128'h11);
    tick();
    chk("pop2", out_result, 128'h22);
    tick();
    chk("empty_after_pops", occupancy, 3'd0);

    // Push and pop together on a full buffer, across pointer wrap
    drive(1, 128'hA1, 5'd1, 4'b0000, 0, 0); tick();
    drive(1, 128'hA2, 5'd1, 4'b0000, 0, 0); tick();
    drive(1, 128'hA3, 5'd1, 4'b0000, 1, 0);
    #1;
    chk("full_pp_in_ready", in_ready, 1'b1);
    tick();
    chk("full_pp_occ", occupancy, 3'd2);
    chk("full_pp_head", out_result, 128'hA2);
    drive(1, 128'hA4, 5'd1, 4'b0000, 1, 0); tick();
    chk("wrap_head", out_result, 128'hA3);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("flush_occ", occupancy, 3'd0);

    // Upper-half masking
    drive(1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234}, 5'd5, 4'b0000, 0, 0); tick();
    chk("narrow_mask", out_result, {64'h0, 64'h1234});
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234}, 5'd5, 4'b1000, 0, 0); tick();
    chk("wide_pass", out_result, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234});

    // Flush overrides a concurrent push (buffer holds one entry here)
    drive(1, 128'h77, 5'd6, 4'b0100, 0, 1); tick();
    chk("flush_push_occ", occupancy, 3'd0);
    chk("flush_push_valid", out_valid, 1'b0);

`ifdef EX_MEM_FWD_EN
    drive(1, 128'h90, 5'd0, 4'b0100, 0, 0); tick();
    drive(1, 128'h91, 5'd7, 4'b0100, 0, 0); tick();
    chk("fwd_newest_valid", fwd_valid, 1'b1);
    chk("fwd_newest_rd", fwd_rd, 5'd7);
    chk("fwd_newest_data", fwd_data, 64'h91);
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(1, 128'h92, 5'd0, 4'b0100, 0, 0); tick();
    chk("fwd_rd0_none", fwd_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 1); tick();
`endif

    // Reset mid-stream
    drive(1, 128'h55, 5'd2, 4'b0100, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 9) < 6, r, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      if (n == 400) begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset();
      end else begin
        tick();
      end
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DEPTH, default 2, number of buffer entries (legal values 2 or 4).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  execute stage presents an entry.
REQ-005 Port: in_ready  output  1  stage can accept an entry this cycle.
REQ-006 Port: alu_result  input  128  ALU result; [127:64] used only for mul/div.
REQ-007 Port: alu_zero, alu_c_out  input  1 each  ALU flags.
REQ-008 Port: rd_addr  input  5  destination register.
REQ-009 Port: ctl  input  4  {wide, reg_write, mem_read, mem_write}.
REQ-010 Port: store_data  input  64  data for memory write.
REQ-011 Port: flush  input  1  discard all buffered entries.
REQ-012 Port: out_valid  output  1  head entry valid.
REQ-013 Port: out_ready  input  1  memory stage accepts head entry.
REQ-014 Port: out_result, out_store_data, out_rd_addr, out_ctl, out_zero, out_c_out  output  128/64/5/4/1/1  head entry fields.
REQ-015 Port: occupancy  output  3  current entry count.

Function
REQ-016 The block SHALL be a FIFO of DEPTH entries; each entry holds all input fields captured together.
REQ-017 Push SHALL occur on a rising edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 when occupancy < DEPTH, or when occupancy == DEPTH and out_ready is 1 (push and pop on a full buffer in the same cycle).
REQ-019 out_valid SHALL be 1 iff occupancy > 0; out_* fields SHALL drive the head entry with zero-cycle latency from storage.
REQ-020 Latency: an entry pushed into an empty buffer SHALL appear on out_* at the following cycle.
REQ-021 Entries SHALL leave in push order; read/write pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 Pop on empty and push when in_ready=0 SHALL be ignored with no state change.
REQ-024 When ctl.wide=0, the stored out_result[127:64] SHALL be 0 regardless of alu_result[127:64].
REQ-025 flush SHALL set occupancy to 0 and both pointers to 0 on the next edge and SHALL override a push or pop in that cycle.
REQ-026 out_* data fields while out_valid=0 SHALL be 0.

Reset
REQ-027 On reset low, occupancy, pointers, out_valid SHALL be 0 immediately; in_ready SHALL be 1 after reset release.
REQ-028 Reset asserted mid-operation SHALL discard all entries; no partial entry survives.
REQ-029 The entry storage need not be reset, but out_* SHALL read 0 while empty (REQ-026).

Configuration
REQ-030 Macro EX_MEM_FWD_EN: when defined, extra outputs fwd_valid (1), fwd_rd (5) and fwd_data (64) SHALL present the newest buffered entry with reg_write=1 and rd_addr != 0 (data = result[63:0]), fwd_valid=0 if none exists.
REQ-031 Without EX_MEM_FWD_EN the forwarding ports and logic SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Reset then single push (result=0x5, rd=3, ctl=0100) with out_ready=1 -> out_valid=1 next cycle with out_result=0x5, then occupancy returns to 0.
REQ-033 Push 3 entries with out_ready=0, DEPTH=2 -> in_ready=0 after 2nd; 3rd held; occupancy=2; pops return entries 1,2 in order.
REQ-034 Full buffer, in_valid=1 and out_ready=1 simultaneously -> push accepted, occupancy stays 2, order preserved across pointer wrap.
REQ-035 Push wide=0 with alu_result[127:64]=0xFFFF... -> out_result[127:64]=0; wide=1 -> upper half passed unchanged.
REQ-036 flush with in_valid=1 on a 1-entry buffer -> occupancy=0, out_valid=0 next cycle; reset asserted mid-stream -> out_valid=0 immediately.
REQ-037 With EX_MEM_FWD_EN, push rd=0 reg_write=1 then rd=7 reg_write=1 -> fwd_valid=1, fwd_rd=7; push rd=0 only -> fwd_valid=0.
